thread_scheduler: RTL

Per-thread issue scheduler for the fine-grained multithreaded front end. It tracks each hardware thread's run state: ready, waiting on a cache-line fill, or draining after an exception. Each cycle it selects, round-robin, one ready thread for `stage_if` to fetch. It produces the `stalled` mask consumed by the IF and TL stages and replaces the constant-zero stall handling in the current top level.

---
 rtl/thread_scheduler_pkg.sv | 18 +
 rtl/thread_scheduler_if.sv | 36 +++
 rtl/thread_scheduler_rr_arbiter.sv | 30 +++
 rtl/thread_scheduler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// Shared types for the thread scheduler: thread ids, physical pointers,
// cache-line slices and the per-thread run state.
package thread_scheduler_pkg;

   localparam int N_THREADS = 8;
   localparam int LINE_BITS = 4;

   typedef logic [2:0]              threadid_t;
   typedef logic [19:0]             pptr_t;
   typedef logic [19-LINE_BITS:0]   line_t;

   typedef enum logic [1:0] {
      READY = 2'd0,
      MISS  = 2'd1,
      DRAIN = 2'd2
   } thread_state_t;

endpackage

// File: rtl/thread_scheduler_if.sv
// Event and issue signals between the pipeline and the thread scheduler.
// The scheduler takes the slave side; the pipeline (or a bench) the master.
interface thread_scheduler_if #(
   parameter int N_THREADS = 8
);
   import thread_scheduler_pkg::*;

   logic                 miss_en;
   threadid_t            miss_thread;
   pptr_t                miss_addr;
   logic                 fill_en;
   pptr_t                fill_addr;
   logic                 exc_en;
   threadid_t            exc_thread;
   logic                 issue_ready;
   logic                 issue_valid;
   threadid_t            issue_thread;
   logic [N_THREADS-1:0] stalled;

   modport master (
      output miss_en, miss_thread, miss_addr,
      output fill_en, fill_addr,
      output exc_en, exc_thread,
      output issue_ready,
      input  issue_valid, issue_thread, stalled
   );

   modport slave (
      input  miss_en, miss_thread, miss_addr,
      input  fill_en, fill_addr,
      input  exc_en, exc_thread,
      input  issue_ready,
      output issue_valid, issue_thread, stalled
   );

endinterface

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the pointer, searching upward with wrap-around.
module rr_arbiter #(
   parameter int WIDTH = 8,
   parameter int ID_W  = 3
) (
   input  logic [WIDTH-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [WIDTH-1:0] o_grant,
   output logic [ID_W-1:0]  o_id,
   output logic             o_valid
);

   // Scan the WIDTH positions following the pointer; first hit wins.
   always_comb begin
      o_grant = '0;
      o_id    = '0;
      o_valid = 1'b0;
      for (int k = 1; k <= WIDTH; k++) begin
         int idx;
         idx = (int'(i_ptr) + k) % WIDTH;
         if (!o_valid && i_req[idx]) begin
            o_grant[idx] = 1'b1;
            o_id         = ID_W'(idx);
            o_valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/thread_scheduler.sv
// Per-thread run-state tracking (READY / MISS / DRAIN) with a registered
// round-robin fetch grant and a registered stall mask.
module thread_scheduler #(
   parameter int N_THREADS    = 8,
   parameter int LINE_BITS    = thread_scheduler_pkg::LINE_BITS,
   parameter int EXC_DRAIN    = 8,
   parameter int MISS_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   thread_scheduler_if.slave   bus
);
   import thread_scheduler_pkg::*;

   localparam int LW      = 20 - LINE_BITS;
   localparam int DRAIN_W = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;
   localparam int TMO_W   = (MISS_TIMEOUT > 0) ? $clog2(MISS_TIMEOUT + 1) : 1;
   localparam int ID_W    = $bits(threadid_t);

   thread_state_t        r_state     [N_THREADS];
   logic [LW-1:0]        r_wait_line [N_THREADS];
   logic [DRAIN_W-1:0]   r_drain     [N_THREADS];
   logic [TMO_W-1:0]     r_tmo       [N_THREADS];

   thread_state_t        w_state_nxt [N_THREADS];
   logic [LW-1:0]        w_wait_nxt  [N_THREADS];
   logic [DRAIN_W-1:0]   w_drain_nxt [N_THREADS];
   logic [TMO_W-1:0]     w_tmo_nxt   [N_THREADS];

   logic [N_THREADS-1:0] w_ready_nxt;
   logic [N_THREADS-1:0] w_grant;
   threadid_t            w_grant_id;
   logic                 w_arb_valid;
   logic [LW-1:0]        w_miss_line;
   logic [LW-1:0]        w_fill_line;

   threadid_t            r_ptr;
   logic                 r_issue_valid;
   threadid_t            r_issue_thread;
   logic [N_THREADS-1:0] r_stalled;

   assign w_miss_line = bus.miss_addr[19:LINE_BITS];
   assign w_fill_line = bus.fill_addr[19:LINE_BITS];

   // State register: run state and counters reset, captured line does not.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_THREADS; i++) begin
         if (rst) begin
            r_state[i] <= READY;
            r_drain[i] <= '0;
            r_tmo[i]   <= '0;
         end else begin
            r_state[i] <= w_state_nxt[i];
            r_drain[i] <= w_drain_nxt[i];
            r_tmo[i]   <= w_tmo_nxt[i];
         end
         r_wait_line[i] <= w_wait_nxt[i];
      end
   end

   // Next-state: exception beats miss, miss beats fill/timeout; a miss
   // satisfied by a same-cycle fill of its line never leaves READY.
   always_comb begin
      for (int i = 0; i < N_THREADS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_wait_nxt[i]  = r_wait_line[i];
         w_drain_nxt[i] = r_drain[i];
         w_tmo_nxt[i]   = r_tmo[i];
         if (bus.exc_en && bus.exc_thread == threadid_t'(i)) begin
            w_state_nxt[i] = DRAIN;
            w_drain_nxt[i] = DRAIN_W'(EXC_DRAIN - 1);
         end else if (bus.miss_en && bus.miss_thread == threadid_t'(i) &&
                      r_state[i] != DRAIN) begin
            if (bus.fill_en && w_fill_line == w_miss_line) begin
               w_state_nxt[i] = READY;
            end else begin
               w_state_nxt[i] = MISS;
               w_wait_nxt[i]  = w_miss_line;
               w_tmo_nxt[i]   = '0;
            end
         end else if (r_state[i] == MISS) begin
            if (bus.fill_en && w_fill_line == r_wait_line[i]) begin
               w_state_nxt[i] = READY;
            end else if (MISS_TIMEOUT != 0 && r_tmo[i] == TMO_W'(MISS_TIMEOUT)) begin
               w_state_nxt[i] = READY;
            end else begin
               w_tmo_nxt[i] = r_tmo[i] + 1'b1;
            end
         end else if (r_state[i] == DRAIN) begin
            if (r_drain[i] == '0) begin
               w_state_nxt[i] = READY;
            end else begin
               w_drain_nxt[i] = r_drain[i] - 1'b1;
            end
         end
      end
   end

   // Output decode: arbitration and stall mask look at the next-state mask.
   always_comb begin
      w_ready_nxt = '0;
      for (int i = 0; i < N_THREADS; i++) begin
         w_ready_nxt[i] = (w_state_nxt[i] == READY);
      end
   end

   rr_arbiter #(
      .WIDTH (N_THREADS),
      .ID_W  (ID_W)
   ) u_arb (
      .i_req   (w_ready_nxt),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_id    (w_grant_id),
      .o_valid (w_arb_valid)
   );

   // Issue stage: one-cycle grant strobe, pointer follows each grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_issue_valid  <= 1'b0;
         r_issue_thread <= '0;
         r_ptr          <= threadid_t'(N_THREADS - 1);
         r_stalled      <= '0;
      end else begin
         r_issue_valid <= bus.issue_ready && w_arb_valid;
         if (bus.issue_ready && w_arb_valid) begin
            r_issue_thread <= w_grant_id;
            r_ptr          <= w_grant_id;
         end
         r_stalled <= ~w_ready_nxt;
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      w_arb_valid |-> $onehot(w_grant));

   assign bus.issue_valid  = r_issue_valid;
   assign bus.issue_thread = r_issue_thread;
   assign bus.stalled      = r_stalled;

endmodule
